// File: rtl/srl_ctrl_pkg.sv
// Shared constants and state encoding for the SRL delay-line controller.
package srl_ctrl_pkg;

    localparam int unsigned SRL_LEN    = 32;
    localparam int unsigned SRL_ADDR_W = 5;
    localparam int unsigned CHAIN_LEN  = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2
    } state_e;

endpackage

// File: rtl/srl_tap_sel.sv
// Registered tap-LUT select of the SRL cascade outputs plus the out_valid qualifier pipeline.
module srl_tap_sel #(
    parameter int unsigned CHAIN_LUTS = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHAIN_LUTS-1:0] srl_q,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  accept,
    input  logic                  qualify,
    input  logic                  cancel,
    output logic                  out_valid,
    output logic                  out_data
);

    logic pend_q;
    logic take;

    // The chain shifts on the accept edge; the tap is read one edge later.
    assign take = pend_q & ~cancel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
        end else begin
            pend_q    <= accept & qualify;
            out_valid <= take;
            if (take) begin
                out_data <= srl_q[sel];
            end
        end
    end

endmodule

// File: rtl/srl_delay_ctrl.sv
// Controller for an external SRLC32E cascade used as a programmable 1-bit delay line.
// Define SRL_DELAY_CTRL_FLUSH_EN to zero the chain on every cfg_load before running.
module srl_delay_ctrl
    import srl_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LUTS = 4,
    parameter int unsigned DEPTH_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DEPTH_W-1:0]    cfg_depth,
    input  logic                  cfg_load,
    input  logic                  in_valid,
    input  logic                  in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_data,
    output logic                  busy,
    output logic                  srl_ce,
    output logic                  srl_d,
    output logic [SRL_ADDR_W-1:0] srl_a,
    input  logic [CHAIN_LUTS-1:0] srl_q
);

    localparam int unsigned ChainLen = SRL_LEN * CHAIN_LUTS;
    localparam int unsigned CntW     = $clog2(ChainLen) + 1;
    localparam int unsigned SelW     = DEPTH_W - SRL_ADDR_W;
    localparam logic [CntW-1:0] FillMax = CntW'(ChainLen);

    state_e              state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [CntW-1:0]     fill_cnt_q, fill_cnt_d;
    logic                accept;
    logic                qualify;

`ifdef SRL_DELAY_CTRL_FLUSH_EN
    localparam logic [CntW-1:0] FlushLast = CntW'(ChainLen - 1);
    logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        fill_cnt_d = fill_cnt_q;
        in_ready   = 1'b0;
        accept     = 1'b0;
        busy       = 1'b0;
        srl_ce     = 1'b0;
        srl_d      = 1'b0;
`ifdef SRL_DELAY_CTRL_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif

        unique case (state_q)
            StIdle: ;
`ifdef SRL_DELAY_CTRL_FLUSH_EN
            StFlush: begin
                busy   = 1'b1;
                srl_ce = 1'b1;
                if (flush_cnt_q == FlushLast) begin
                    state_d     = StRun;
                    fill_cnt_d  = '0;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
`endif
            StRun: begin
                in_ready = ~cfg_load;
                accept   = in_valid & in_ready;
                srl_ce   = accept;
                srl_d    = in_data;
                if (accept && fill_cnt_q != FillMax) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A reload wins over everything else, from any state.
        if (cfg_load) begin
            depth_d    = cfg_depth;
            fill_cnt_d = '0;
`ifdef SRL_DELAY_CTRL_FLUSH_EN
            state_d     = StFlush;
            flush_cnt_d = '0;
`else
            state_d     = StRun;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            depth_q    <= '0;
            fill_cnt_q <= '0;
`ifdef SRL_DELAY_CTRL_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            fill_cnt_q <= fill_cnt_d;
`ifdef SRL_DELAY_CTRL_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign srl_a   = depth_q[SRL_ADDR_W-1:0];
    assign qualify = fill_cnt_q >= CntW'(depth_q);

    srl_tap_sel #(
        .CHAIN_LUTS (CHAIN_LUTS),
        .SEL_W      (SelW)
    ) u_tap_sel (
        .clk       (clk),
        .rst_n     (rst_n),
        .srl_q     (srl_q),
        .sel       (depth_q[DEPTH_W-1:SRL_ADDR_W]),
        .accept    (accept),
        .qualify   (qualify),
        .cancel    (cfg_load),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl: behavioural 4x32 SRL cascade plus an accept-history reference model.
module tb_srl_delay_ctrl;

`ifdef SRL_DELAY_CTRL_FLUSH_EN
    localparam int FLUSH_CYC = 128;
`else
    localparam int FLUSH_CYC = 0;
`endif

    logic       clk, rst_n;
    logic [6:0] cfg_depth;
    logic       cfg_load, in_valid, in_data;
    logic       in_ready, out_valid, out_data, busy, srl_ce, srl_d;
    logic [4:0] srl_a;
    logic [3:0] srl_q;

    srl_delay_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_depth (cfg_depth),
        .cfg_load  (cfg_load),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .srl_ce    (srl_ce),
        .srl_d     (srl_d),
        .srl_a     (srl_a),
        .srl_q     (srl_q)
    );

    // Behavioural SRL cascade: bit 0 is the newest sample.
    logic [127:0] chain;
    always @(posedge clk) if (srl_ce) chain <= {chain[126:0], srl_d};
    always_comb begin
        srl_q = '0;
        for (int k = 0; k < 4; k++) srl_q[k] = chain[32*k + int'(srl_a)];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: accepted samples since the last load, expected pulses with due edge.
    bit   m_run;
    int   flush_left;
    int   m_depth;
    bit   hist[$];
    int   exp_due[$];
    bit   exp_dat[$];
    int   edge_n;
    int   pulse_cnt;
    int   acc_cnt;
    bit   last_busy;

    task automatic model_clear();
        m_run = 0; flush_left = 0; m_depth = 0;
        hist.delete(); exp_due.delete(); exp_dat.delete();
    endtask

    // Called at a negedge; drives one cycle and checks the cycle's outputs.
    task automatic step(input bit ld, input int dep, input bit v, input bit d);
        bit exp_ready, acc, flushing, want;
        cfg_load = ld; cfg_depth = 7'(dep); in_valid = v; in_data = d;
        flushing  = flush_left > 0;
        exp_ready = m_run && !ld;
        acc       = v && exp_ready;
        #1;
        last_busy = busy;
        n_tests++;
        if (in_ready !== exp_ready) begin
            n_fail++; $display("FAIL in_ready: got %b want %b (edge %0d)", in_ready, exp_ready, edge_n);
        end
        n_tests++;
        if (busy !== flushing) begin
            n_fail++; $display("FAIL busy: got %b want %b (edge %0d)", busy, flushing, edge_n);
        end
        n_tests++;
        if (srl_ce !== (flushing || acc)) begin
            n_fail++; $display("FAIL srl_ce: got %b want %b (edge %0d)", srl_ce, flushing || acc, edge_n);
        end
        if (flushing || acc) begin
            n_tests++;
            if (srl_d !== (flushing ? 1'b0 : d)) begin
                n_fail++; $display("FAIL srl_d: got %b want %b (edge %0d)", srl_d, flushing ? 1'b0 : d, edge_n);
            end
        end
        @(posedge clk);
        edge_n++;
        if (ld && exp_due.size() > 0 && exp_due[0] == edge_n) begin
            void'(exp_due.pop_front()); void'(exp_dat.pop_front());
        end
        if (acc) begin
            acc_cnt++;
            if (hist.size() >= m_depth) begin
                hist.push_back(d);
                exp_due.push_back(edge_n + 1);
                exp_dat.push_back(hist[hist.size() - 1 - m_depth]);
            end else begin
                hist.push_back(d);
            end
        end
        if (ld) begin
            m_depth = dep; hist.delete();
            flush_left = FLUSH_CYC; m_run = (FLUSH_CYC == 0);
        end else if (flushing) begin
            flush_left--;
            if (flush_left == 0) m_run = 1;
        end
        @(negedge clk);
        want = exp_due.size() > 0 && exp_due[0] == edge_n;
        n_tests++;
        if (out_valid !== want) begin
            n_fail++; $display("FAIL out_valid: got %b want %b (edge %0d)", out_valid, want, edge_n);
        end
        if (out_valid === 1'b1) pulse_cnt++;
        if (want) begin
            n_tests++;
            if (out_data !== exp_dat[0]) begin
                n_fail++; $display("FAIL out_data: got %b want %b (edge %0d)", out_data, exp_dat[0], edge_n);
            end
            void'(exp_due.pop_front()); void'(exp_dat.pop_front());
        end
    endtask

    task automatic wait_flush();
        while (flush_left > 0) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b1; in_data = 1'b1; cfg_load = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, srl_ce, srl_d, out_valid, out_data} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {in_ready, busy, srl_ce, srl_d, out_valid, out_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 1, 1);  // idle: must not accept
    endtask

    task automatic test_flush();
        int cnt;
        step(1, 5, 0, 0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 0);
            if (last_busy) cnt++;
            else break;
        end
        n_tests++;
        if (cnt != FLUSH_CYC) begin
            n_fail++; $display("FAIL flush_len: got %0d want %0d", cnt, FLUSH_CYC);
        end
    endtask

    task automatic test_depth5();
        logic [6:0] pat;
        pat = 7'b1001101;
        pulse_cnt = 0;
        for (int i = 0; i < 60; i++) step(0, 0, 1, i < 7 ? pat[i] : 1'($urandom));
        step(0, 0, 0, 0);
        n_tests++;
        if (pulse_cnt != 55) begin
            n_fail++; $display("FAIL depth5_pulses: got %0d want 55", pulse_cnt);
        end
    endtask

    task automatic test_depth100();
        step(1, 100, 0, 0);
        wait_flush();
        pulse_cnt = 0;
        for (int i = 0; i < 150; i++) step(0, 0, 1, 1'($urandom));
        step(0, 0, 0, 0);
        n_tests++;
        if (pulse_cnt != 50) begin
            n_fail++; $display("FAIL depth100_pulses: got %0d want 50", pulse_cnt);
        end
    endtask

    task automatic test_depth0_gapped();
        step(1, 0, 0, 0);
        wait_flush();
        pulse_cnt = 0; acc_cnt = 0;
        for (int i = 0; i < 80; i++) step(0, 0, 1'($urandom), 1'($urandom));
        step(0, 0, 0, 0);
        n_tests++;
        if (pulse_cnt != acc_cnt) begin
            n_fail++; $display("FAIL depth0_pulses: got %0d want %0d", pulse_cnt, acc_cnt);
        end
    endtask

    task automatic test_reload();
        step(1, 3, 0, 0);
        wait_flush();
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1'($urandom));
        // Previous accept is in flight; reload cancels it and rejects this sample.
        pulse_cnt = 0;
        step(1, 3, 1, 1);
        step(0, 0, 0, 0);
        n_tests++;
        if (pulse_cnt != 0) begin
            n_fail++; $display("FAIL reload_cancel: got %0d pulses want 0", pulse_cnt);
        end
        wait_flush();
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1'($urandom));
        step(0, 0, 0, 0);
        n_tests++;
        if (pulse_cnt != 7) begin
            n_fail++; $display("FAIL reload_pulses: got %0d want 7", pulse_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        step(1, 2, 0, 0);
        wait_flush();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1'($urandom));
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) chain[32*i +: 32] = $urandom;
        rst_n = 1'b0; cfg_load = 1'b0; cfg_depth = '0; in_valid = 1'b0; in_data = 1'b0;
        edge_n = 0; pulse_cnt = 0; acc_cnt = 0; last_busy = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_flush();
        test_depth5();
        test_depth100();
        test_depth0_gapped();
        test_reload();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
